// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST address sequencer.
//   state_t      - sequencer states (IDLE, RUN, DONE)
//   BG_*         - data-background select encodings
//   CHECK_BASE() - alternating 1010... base word for checkerboard/stripe,
//                  returned BG_MAX_W bits wide; callers keep the low DATA_W bits.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BG_ZERO   = 2'd0;
  localparam logic [1:0] BG_ONE    = 2'd1;
  localparam logic [1:0] BG_CHECK  = 2'd2;
  localparam logic [1:0] BG_STRIPE = 2'd3;

  // Widest background word the helper can build.
  localparam int BG_MAX_W = 64;

  // Bit i is set for odd i below w, i.e. the low w bits equal {w/2{2'b10}}.
  function automatic logic [BG_MAX_W-1:0] CHECK_BASE(input int w);
    logic [BG_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BG_MAX_W; i++) begin
      r[i] = (i < w) && ((i % 2) == 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_bg_gen.sv
// bist_bg_gen: combinational data-background word for one address.
// Only used when BIST_ADDR_GEN_DATA_EN is defined; the top registers the result.
//   addr_lsb  in   address bit 0 (only bit the patterns depend on)
//   sel       in   background select (BG_ZERO/BG_ONE/BG_CHECK/BG_STRIPE)
//   inv       in   invert the selected pattern
//   word      out  DATA_W-bit background word
module bist_bg_gen
  import bist_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              addr_lsb,
  input  logic [1:0]        sel,
  input  logic              inv,
  output logic [DATA_W-1:0] word
);

  localparam logic [BG_MAX_W-1:0] BASE_FULL = CHECK_BASE(DATA_W);
  localparam logic [DATA_W-1:0]   BASE      = BASE_FULL[DATA_W-1:0];

  logic [DATA_W-1:0] pat;

  always_comb begin
    pat = '0;
    case (sel)
      BG_ZERO:   pat = '0;
      BG_ONE:    pat = '1;
      BG_CHECK:  pat = BASE ^ {DATA_W{addr_lsb}};
      BG_STRIPE: pat = BASE;
      default:   pat = '0;
    endcase
    word = pat ^ {DATA_W{inv}};
  end

endmodule

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: BIST address sequencer. Sweeps the inclusive window
// [lo_addr, hi_addr] ascending or descending under a start/busy/done
// handshake, with per-beat stall (adv=0) and abort.
// Optional feature macro: BIST_ADDR_GEN_DATA_EN adds a registered
// data-background word aligned to each address.
//   clk, rst          clock, synchronous active-high reset
//   start             begin sweep (sampled in IDLE only)
//   dir               1 = ascending lo->hi, 0 = descending hi->lo
//   lo_addr, hi_addr  window bounds, latched at start
//   adv               advance enable, 0 holds the current beat
//   abort             end sweep without done
//   addr, addr_vld    current beat address and its valid
//   last              current beat is the final one
//   busy              sweep in progress (state != IDLE)
//   done              one-cycle completion pulse
//   cfg_err           one-cycle pulse, start rejected because lo_addr > hi_addr
//   bg_sel, bg_inv    background select/invert, latched at start (macro only)
//   data_t            background word for addr (macro only)
module bist_addr_gen
  import bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  input  logic              adv,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef BIST_ADDR_GEN_DATA_EN
  ,
  input  logic [1:0]        bg_sel,
  input  logic              bg_inv,
  output logic [DATA_W-1:0] data_t
`endif
);

  state_t            state;
  logic              dir_q;
  logic [ADDR_W-1:0] end_q;

  logic              cfg_bad;
  logic              load;
  logic              step;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] step_addr;

  assign cfg_bad    = lo_addr > hi_addr;
  assign start_addr = dir ? lo_addr : hi_addr;
  assign step_addr  = dir_q ? (addr + ADDR_W'(1)) : (addr - ADDR_W'(1));
  assign load       = (state == IDLE) && start && !cfg_bad;
  // A step is only taken when the current beat is not the last one, so the
  // address never wraps at either end of the address space.
  assign step       = (state == RUN) && !abort && adv && !last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir_q    <= 1'b1;
      end_q    <= '0;
      addr     <= '0;
      addr_vld <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_bad) begin
            cfg_err <= 1'b1;
          end else if (load) begin
            dir_q    <= dir;
            end_q    <= dir ? hi_addr : lo_addr;
            addr     <= start_addr;
            addr_vld <= 1'b1;
            last     <= (lo_addr == hi_addr);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            addr_vld <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (adv && last) begin
            addr_vld <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (step) begin
            addr <= step_addr;
            last <= (step_addr == end_q);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          addr_vld <= 1'b0;
          last     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef BIST_ADDR_GEN_DATA_EN
  logic [1:0]        sel_q;
  logic              inv_q;
  logic              gen_lsb;
  logic [1:0]        gen_sel;
  logic              gen_inv;
  logic [DATA_W-1:0] gen_word;

  // In IDLE the word is built for the first address from the live select
  // inputs; during the sweep it is built for the next address from the
  // values latched at start, so data_t lands on the same edge as addr.
  assign gen_lsb = (state == IDLE) ? start_addr[0] : step_addr[0];
  assign gen_sel = (state == IDLE) ? bg_sel : sel_q;
  assign gen_inv = (state == IDLE) ? bg_inv : inv_q;

  bist_bg_gen #(
    .DATA_W(DATA_W)
  ) u_bg_gen (
    .addr_lsb(gen_lsb),
    .sel     (gen_sel),
    .inv     (gen_inv),
    .word    (gen_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= BG_ZERO;
      inv_q  <= 1'b0;
      data_t <= '0;
    end else if (load) begin
      sel_q  <= bg_sel;
      inv_q  <= bg_inv;
      data_t <= gen_word;
    end else if (step) begin
      data_t <= gen_word;
    end
  end
`endif

endmodule

// File: tb/tb_bist_addr_gen.sv
// tb_bist_addr_gen: self-checking bench for bist_addr_gen.
// Directed scenarios from the sequencer's behaviour plus randomized sweeps
// (random windows, directions, stalls and mid-sweep input noise) checked
// against an expected-address list built from the window bounds.
// Data-background checks are compiled when BIST_ADDR_GEN_DATA_EN is defined.
module tb_bist_addr_gen;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic              adv;
  logic              abort;
  logic [ADDR_W-1:0] addr;
  logic              addr_vld;
  logic              last;
  logic              busy;
  logic              done;
  logic              cfg_err;
`ifdef BIST_ADDR_GEN_DATA_EN
  logic [1:0]        bg_sel;
  logic              bg_inv;
  logic [DATA_W-1:0] data_t;
`endif

  int checks = 0;
  int errors = 0;

  bist_addr_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .lo_addr (lo_addr),
    .hi_addr (hi_addr),
    .adv     (adv),
    .abort   (abort),
    .addr    (addr),
    .addr_vld(addr_vld),
    .last    (last),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
`ifdef BIST_ADDR_GEN_DATA_EN
    ,
    .bg_sel  (bg_sel),
    .bg_inv  (bg_inv),
    .data_t  (data_t)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef BIST_ADDR_GEN_DATA_EN
  // Background word from its plain description: alternating 1010.. for
  // stripe, flipped on odd addresses for checkerboard, then optional invert.
  function automatic logic [DATA_W-1:0] bg_model(input logic [1:0] s, input logic inv,
                                                 input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (s)
        2'd0: w[i] = 1'b0;
        2'd1: w[i] = 1'b1;
        2'd2: w[i] = ((i % 2) == 1) ? ~a[0] : a[0];
        default: w[i] = ((i % 2) == 1);
      endcase
    end
    return inv ? ~w : w;
  endfunction
`endif

  // One full sweep starting in IDLE. Adv per RUN cycle comes from pat
  // (bit per cycle) when use_pat is set, otherwise random with stall_pct.
  task automatic run_sweep(input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] h,
                           input logic d, input int stall_pct, input bit use_pat,
                           input logic [31:0] pat, input logic [1:0] sel,
                           input logic ins, input bit noise);
    logic [ADDR_W-1:0] q[$];
    int n;
    int idx;
    int cyc;
    bit fin;
    logic a;
    q = {};
    n = int'(h) - int'(l) + 1;
    for (int i = 0; i < n; i++) begin
      if (d) q.push_back(ADDR_W'(int'(l) + i));
      else   q.push_back(ADDR_W'(int'(h) - i));
    end
    lo_addr = l;
    hi_addr = h;
    dir = d;
    adv = 1'b1;
    start = 1'b1;
`ifdef BIST_ADDR_GEN_DATA_EN
    bg_sel = sel;
    bg_inv = ins;
`endif
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 4 * n + 40) begin
      checks++;
      if ({busy, addr_vld, last, done, cfg_err} !== {1'b1, 1'b1, (idx == n - 1), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sweep_ctrl lo=%0d hi=%0d beat=%0d: busy/vld/last/done/cfg_err=%b required %b",
                 l, h, idx, {busy, addr_vld, last, done, cfg_err},
                 {1'b1, 1'b1, (idx == n - 1), 1'b0, 1'b0});
      end
      checks++;
      if (addr !== q[idx]) begin
        errors++;
        $display("FAIL sweep_addr lo=%0d hi=%0d dir=%0d beat=%0d: addr=%0d required %0d",
                 l, h, d, idx, addr, q[idx]);
      end
`ifdef BIST_ADDR_GEN_DATA_EN
      checks++;
      if (data_t !== bg_model(sel, ins, q[idx])) begin
        errors++;
        $display("FAIL sweep_data addr=%0d sel=%0d inv=%0d: data_t=%h required %h",
                 q[idx], sel, ins, data_t, bg_model(sel, ins, q[idx]));
      end
`else
      if (sel != 2'd0 && ins) a = 1'b1;
`endif
      if (use_pat) a = (cyc < 32) ? pat[cyc] : 1'b1;
      else         a = ($urandom_range(99) >= stall_pct);
      adv = a;
      if (noise) begin
        lo_addr = ADDR_W'($urandom);
        hi_addr = ADDR_W'($urandom);
        dir     = 1'($urandom_range(1));
        start   = 1'($urandom_range(1));
`ifdef BIST_ADDR_GEN_DATA_EN
        bg_sel  = 2'($urandom_range(3));
        bg_inv  = 1'($urandom_range(1));
`endif
      end
      tick();
      cyc++;
      if (a) begin
        if (idx == n - 1) fin = 1;
        else idx++;
      end
    end
    start = 1'b0;
    adv = 1'b1;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout lo=%0d hi=%0d: final beat not consumed within %0d cycles",
               l, h, cyc);
      return;
    end
    checks++;
    if ({done, busy, addr_vld, last} !== 4'b1100) begin
      errors++;
      $display("FAIL sweep_done lo=%0d hi=%0d: done/busy/vld/last=%b required 1100",
               l, h, {done, busy, addr_vld, last});
    end
    tick();
    checks++;
    if ({done, busy, addr_vld, last} !== 4'b0000) begin
      errors++;
      $display("FAIL sweep_idle lo=%0d hi=%0d: done/busy/vld/last=%b required 0000",
               l, h, {done, busy, addr_vld, last});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dir = 1'b1;
    lo_addr = '0;
    hi_addr = '0;
    adv = 1'b1;
    abort = 1'b0;
`ifdef BIST_ADDR_GEN_DATA_EN
    bg_sel = 2'd0;
    bg_inv = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if ({addr_vld, last, busy, done, cfg_err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: vld/last/busy/done/cfg_err=%b required 00000",
               {addr_vld, last, busy, done, cfg_err});
    end
    checks++;
    if (addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: addr=%0d required 0", addr);
    end
`ifdef BIST_ADDR_GEN_DATA_EN
    checks++;
    if (data_t !== '0) begin
      errors++;
      $display("FAIL reset_data: data_t=%h required 00", data_t);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ascending();
    run_sweep(10'd3, 10'd6, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_desc_stall();
    // adv 1,0,1,1 -> addresses 2,1,1,0 then done
    run_sweep(10'd0, 10'd2, 1'b0, 0, 1'b1, 32'hFFFF_FFFD, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_top_range();
    run_sweep(10'd1022, 10'd1023, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b1, 1'b0);
    checks++;
    if (addr !== 10'd1023) begin
      errors++;
      $display("FAIL top_hold: addr=%0d required 1023", addr);
    end
    run_sweep(10'd0, 10'd1, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 1'b0);
    checks++;
    if (addr !== 10'd0) begin
      errors++;
      $display("FAIL bottom_hold: addr=%0d required 0", addr);
    end
    run_sweep(10'd5, 10'd5, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 2'd0, 1'b1, 1'b0);
    run_sweep(10'd5, 10'd5, 1'b0, 50, 1'b0, 32'h0, 2'd3, 1'b1, 1'b1);
  endtask

  task automatic test_cfg_err();
    lo_addr = 10'd7;
    hi_addr = 10'd4;
    dir = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({cfg_err, busy, addr_vld, done} !== 4'b1000) begin
      errors++;
      $display("FAIL cfg_err_pulse: cfg_err/busy/vld/done=%b required 1000",
               {cfg_err, busy, addr_vld, done});
    end
    tick();
    checks++;
    if ({cfg_err, busy, addr_vld, done} !== 4'b0000) begin
      errors++;
      $display("FAIL cfg_err_clear: cfg_err/busy/vld/done=%b required 0000",
               {cfg_err, busy, addr_vld, done});
    end
  endtask

  task automatic test_abort();
    lo_addr = 10'd10;
    hi_addr = 10'd20;
    dir = 1'b1;
    adv = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({addr_vld, addr} !== {1'b1, 10'd12}) begin
      errors++;
      $display("FAIL abort_third_beat: vld=%b addr=%0d required vld=1 addr=12", addr_vld, addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, addr_vld, last, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: busy/vld/last/done=%b required 0000",
               {busy, addr_vld, last, done});
    end
    // restart straight away; first beat also proves no late done
    run_sweep(10'd30, 10'd33, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b1, 1'b0);
    // abort wins over adv on the final beat
    lo_addr = 10'd40;
    hi_addr = 10'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    adv = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, addr_vld, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_priority: busy/vld/done=%b required 000", {busy, addr_vld, done});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b required 0", done);
    end
  endtask

  task automatic test_reset_mid();
    lo_addr = 10'd100;
    hi_addr = 10'd110;
    dir = 1'b1;
    adv = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({addr, addr_vld, last, busy, done, cfg_err} !== {10'd0, 5'b00000}) begin
      errors++;
      $display("FAIL reset_mid: addr=%0d vld/last/busy/done/cfg_err=%b required 0 00000",
               addr, {addr_vld, last, busy, done, cfg_err});
    end
    tick();
    checks++;
    if ({busy, done, addr_vld} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_after: busy/done/vld=%b required 000", {busy, done, addr_vld});
    end
  endtask

`ifdef BIST_ADDR_GEN_DATA_EN
  task automatic test_data();
    logic [DATA_W-1:0] seen0;
    logic [DATA_W-1:0] seen1;
    for (int k = 0; k < 2; k++) begin
      lo_addr = 10'd0;
      hi_addr = 10'd1;
      dir = 1'b1;
      adv = 1'b1;
      bg_sel = 2'd2;
      bg_inv = 1'(k);
      start = 1'b1;
      tick();
      start = 1'b0;
      bg_sel = 2'd1;
      bg_inv = ~bg_inv;
      seen0 = data_t;
      tick();
      seen1 = data_t;
      checks++;
      if ({seen0, seen1} !== ((k == 0) ? 16'hAA55 : 16'h55AA)) begin
        errors++;
        $display("FAIL data_check inv=%0d: data_t=%h,%h required %h", k, seen0, seen1,
                 (k == 0) ? 16'hAA55 : 16'h55AA);
      end
      tick();
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [ADDR_W-1:0] l;
    logic [ADDR_W-1:0] h;
    int span;
    for (int i = 0; i < 40; i++) begin
      l = ADDR_W'($urandom);
      span = $urandom_range(12);
      if (i % 5 == 0) l = '0;
      if (int'(l) + span > 1023) h = 10'd1023;
      else h = ADDR_W'(int'(l) + span);
      if (i % 7 == 3) begin
        h = 10'd1023;
        l = ADDR_W'(1023 - span);
      end
      run_sweep(l, h, 1'($urandom_range(1)), 30, 1'b0, 32'h0,
                2'($urandom_range(3)), 1'($urandom_range(1)), 1'b1);
      if ($urandom_range(1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_desc_stall();
    test_top_range();
    test_cfg_err();
    test_abort();
    test_reset_mid();
`ifdef BIST_ADDR_GEN_DATA_EN
    test_data();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_addr_gen.md
# bist_addr_gen

Parametrised BIST address sequencer, the successor to the fixed-width load/up/down counter. It sweeps a programmable window [lo_addr, hi_addr] in either direction under a start/busy/done handshake, and honours per-beat stall and abort. Optionally it emits a registered data-background word aligned to each address. It sits between the BIST controller FSM and the SRAM port mux: the controller issues one sweep per march element.

## Interface
- ADDR_W, 10, address width (≥2)
- DATA_W, 8, data-background width (even, ≥2; used only with BIST_ADDR_GEN_DATA_EN)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin sweep; sampled only in IDLE
- dir  input  1  1 = ascending lo→hi, 0 = descending hi→lo; latched at start
- lo_addr  input  ADDR_W  window low bound, inclusive; latched at start
- hi_addr  input  ADDR_W  window high bound, inclusive; latched at start
- adv  input  1  advance enable; 0 = stall, address held
- abort  input  1  terminate sweep, no done
- addr  output  ADDR_W  current address (registered)
- addr_vld  output  1  addr is a valid beat
- last  output  1  addr is the final beat of the sweep
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse, sweep completed
- cfg_err  output  1  one-cycle pulse, start rejected (lo_addr > hi_addr)
- bg_sel  input  2  background select (macro only)
- bg_inv  input  1  invert background (macro only)
- data_t  output  DATA_W  background word for addr (macro only)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start with lo>hi → cfg_err=1 next cycle, stay in IDLE.
  - start otherwise → latch dir/lo/hi; addr ← dir ? lo : hi; go to RUN.
- RUN:
  - addr_vld=1.
  - last = (addr == end), where end = dir ? hi : lo.
  - adv=1 and not last → addr ± 1.
  - adv=1 and last → DONE; addr holds.
  - adv=0 → hold all.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. Inputs lo/hi/dir changing mid-sweep have no effect.
- abort in RUN or DONE → IDLE next cycle, done=0. Abort has priority over adv.
- Arithmetic is ADDR_W-bit. The last check precedes the step, so hi = 2^ADDR_W−1 ascending (or lo = 0 descending) never wraps.
- lo == hi → single beat with last=1 on it.
- Reset values: addr=0, addr_vld=0, last=0, busy=0, done=0, cfg_err=0, data_t=0, state=IDLE.
- rst mid-sweep → all outputs to reset values next edge; no done.

## Timing
- start at edge t → addr_vld/busy high from t+1, first addr at t+1.
- N-beat sweep with adv held high → last at t+N, done at t+N+1, busy low at t+N+2.
- Each adv=0 cycle adds one cycle of latency.
- cfg_err: high at t+1 only; busy stays 0.
- All outputs are registered; there is no combinational input→output path.
- Back-to-back sweeps: start is accepted at the earliest in the cycle busy=0, i.e. t+N+2.

## Configuration
- BIST_ADDR_GEN_DATA_EN defined:
  - Ports bg_sel, bg_inv, data_t exist.
  - data_t is registered with, and aligned to, addr.
  - bg_sel encodings:
    - 0 solid 0
    - 1 solid 1
    - 2 checkerboard: {DATA_W/2{2'b10}} XOR {DATA_W{addr[0]}}
    - 3 column stripe: {DATA_W/2{2'b10}}
  - The final word is XORed with {DATA_W{bg_inv}}.
  - bg_sel and bg_inv are latched at start.
- BIST_ADDR_GEN_DATA_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- bist_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - bg_sel encodings (BG_ZERO, BG_ONE, BG_CHECK, BG_STRIPE)
  - CHECK_BASE(DATA_W) helper
- Sub-module bist_bg_gen: combinational address/sel/inv → background word, instantiated only under BIST_ADDR_GEN_DATA_EN. The top level registers its output.

## Test plan
- Ascending sweep: ADDR_W=10, lo=3, hi=6, dir=1, adv=1, start at t → addr 3,4,5,6 at t+1..t+4; last at t+4; done at t+5; busy low at t+6.
- Descending with stall: lo=0, hi=2, dir=0, adv=0 at t+2 → addr 2,1,1,0; done at t+5; no underflow past 0.
- Top-of-range: lo=1022, hi=1023, dir=1 → addr 1022, 1023, then done; addr never shows 0. lo=hi=5 → one beat with last=1.
- Config error: lo=7, hi=4, start → cfg_err pulse at t+1; busy, addr_vld, done stay 0.
- Abort and reset: abort at third beat → IDLE next cycle, no done, start accepted immediately after. Repeat with rst → all outputs 0.
- Data background (macro defined): DATA_W=8, bg_sel=2, lo=0, hi=1 → data_t 0xAA then 0x55. bg_inv=1 → 0x55 then 0xAA.
